vga_pixel_fetch: RTL and testbench

- Sits between data_ram's VGA read port (A_VGA / vram_o) and the VGA pixel generator.
- Walks the framebuffer line by line and prefetches 48-bit words (6 packed 8-bit pixels) into a two-entry ping-pong buffer.
- Serializes the buffered words into one 8-bit grayscale pixel per display request.
- Replaces the raw address/word coupling between data_ram and the VGA block with a timed, underrun-checked pixel stream.

---
 rtl/vga_pixel_fetch.sv | 228 ++++++++++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fetch.sv
// Framebuffer-to-pixel fetcher for the VGA path.
// The block walks the image one line at a time and prefetches 48-bit words
// (R packed pixels each) into a ping-pong pair of buffers. It then serializes
// one pixel per display request. The pixel and pix_valid outputs are
// registered. A request that finds no valid word sets the sticky underrun flag.
module vga_pixel_fetch #(
  parameter int unsigned   AW        = 17,
  parameter int unsigned   N         = 8,
  parameter int unsigned   R         = 6,
  parameter int unsigned   IMG_W     = 384,
  parameter int unsigned   IMG_H     = 256,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter logic [N-1:0]  BG        = '0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame_start,
  input  logic           line_start,
  input  logic           pix_req,
  input  logic [R*N-1:0] vram_i,
  output logic [AW-1:0]  a_vga,
  output logic [N-1:0]   pixel,
  output logic           pix_valid,
  output logic           underrun
);

  localparam int unsigned WPL = IMG_W / R;
  localparam int unsigned KW  = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned WW  = $clog2(WPL + 1);
  localparam int unsigned LW  = $clog2(IMG_H + 1);

  localparam logic [KW-1:0] KLast = KW'(R - 1);
  localparam logic [WW-1:0] WLast = WW'(WPL - 1);
  localparam logic [WW-1:0] WplW  = WW'(WPL);
  localparam logic [LW-1:0] ImgH  = LW'(IMG_H);
  localparam logic [AW-1:0] WplA  = AW'(WPL);

  typedef enum logic [1:0] {StIdle, StPrefetch, StStream, StLineDone} state_e;

  state_e                  state_q, state_d, st;
  logic [LW-1:0]           line_q, line_d, line_eff;
  logic [AW-1:0]           base_q, base_d, base_eff;
  logic [1:0][R*N-1:0]     buf_q, buf_d;
  logic [1:0]              vld_q, vld_d;
  logic                    cur_q, cur_d;
  logic [KW-1:0]           k_q, k_d;
  logic [WW-1:0]           word_q, word_d;   // index of the word being consumed
  logic [WW-1:0]           fw_q, fw_d;       // index of the next word to fetch
  logic                    pend_q, pend_d;   // a_vga carries a fresh address this cycle
  logic                    pend_buf_q, pend_buf_d;
  logic                    cap_q, cap_d;     // vram_i carries fetched data this cycle
  logic                    cap_buf_q, cap_buf_d;
  logic [AW-1:0]           a_vga_q, a_vga_d;
  logic [N-1:0]            pixel_q, pixel_d;
  logic                    pix_valid_q, pix_valid_d;
  logic                    underrun_q, underrun_d;
  logic                    flush, issue, issue_buf;
  logic [WW-1:0]           issue_w;

  // Next-state logic for the FSM, the buffers, the fetch pipeline and the outputs.
  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    base_d      = base_q;
    buf_d       = buf_q;
    vld_d       = vld_q;
    cur_d       = cur_q;
    k_d         = k_q;
    word_d      = word_q;
    fw_d        = fw_q;
    pend_d      = 1'b0;
    pend_buf_d  = pend_buf_q;
    cap_d       = pend_q;
    cap_buf_d   = pend_buf_q;
    a_vga_d     = a_vga_q;
    pixel_d     = BG;
    pix_valid_d = 1'b0;
    underrun_d  = underrun_q;
    st          = state_q;
    line_eff    = line_q;
    base_eff    = base_q;
    flush       = 1'b0;
    issue       = 1'b0;
    issue_buf   = 1'b0;
    issue_w     = '0;

    // frame_start takes effect before a coincident line_start is evaluated.
    if (frame_start) begin
      st         = StIdle;
      line_eff   = '0;
      base_eff   = BASE_ADDR;
      underrun_d = 1'b0;
      flush      = 1'b1;
    end
    state_d = st;
    line_d  = line_eff;
    base_d  = base_eff;

    if (flush) begin
      vld_d = '0;
      cap_d = 1'b0;
    end else if (cap_q) begin
      buf_d[cap_buf_q] = vram_i;
      vld_d[cap_buf_q] = 1'b1;
    end

    unique case (st)
      StIdle, StLineDone: begin
        if (line_start && (line_eff < ImgH)) begin
          state_d = StPrefetch;
          vld_d   = '0;
          cap_d   = 1'b0;
          cur_d   = 1'b0;
          k_d     = '0;
          word_d  = '0;
          issue   = 1'b1;
          fw_d    = WW'(1);
          // Nothing can be buffered yet, so a request here is an underrun.
          if (pix_req) begin
            pix_valid_d = 1'b1;
            underrun_d  = 1'b1;
          end
        end else begin
          if (line_start) state_d = StIdle;
          pix_valid_d = pix_req;
        end
      end
      StPrefetch: begin
        if ((fw_q == WW'(1)) && (fw_q < WplW)) begin
          issue     = 1'b1;
          issue_buf = 1'b1;
          issue_w   = fw_q;
          fw_d      = fw_q + 1'b1;
        end
        // Word 0 is always the first capture after entering this state.
        if (cap_q) state_d = StStream;
        if (pix_req) begin
          pix_valid_d = 1'b1;
          underrun_d  = 1'b1;
        end
      end
      StStream: begin
        if (pix_req) begin
          pix_valid_d = 1'b1;
          if (!vld_q[cur_q]) begin
            underrun_d = 1'b1;
          end else begin
            pixel_d = buf_q[cur_q][k_q*N +: N];
            if (k_q == KLast) begin
              vld_d[cur_q] = 1'b0;
              cur_d        = ~cur_q;
              k_d          = '0;
              if (fw_q < WplW) begin
                issue     = 1'b1;
                issue_buf = cur_q;
                issue_w   = fw_q;
                fw_d      = fw_q + 1'b1;
              end
              if (word_q == WLast) begin
                state_d = StLineDone;
                line_d  = line_q + 1'b1;
                base_d  = base_q + WplA;
              end else begin
                word_d = word_q + 1'b1;
              end
            end else begin
              k_d = k_q + 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (issue) begin
      a_vga_d    = base_eff + AW'(issue_w);
      pend_d     = 1'b1;
      pend_buf_d = issue_buf;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      line_q      <= '0;
      base_q      <= BASE_ADDR;
      buf_q       <= '0;
      vld_q       <= '0;
      cur_q       <= 1'b0;
      k_q         <= '0;
      word_q      <= '0;
      fw_q        <= '0;
      pend_q      <= 1'b0;
      pend_buf_q  <= 1'b0;
      cap_q       <= 1'b0;
      cap_buf_q   <= 1'b0;
      a_vga_q     <= BASE_ADDR;
      pixel_q     <= BG;
      pix_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      base_q      <= base_d;
      buf_q       <= buf_d;
      vld_q       <= vld_d;
      cur_q       <= cur_d;
      k_q         <= k_d;
      word_q      <= word_d;
      fw_q        <= fw_d;
      pend_q      <= pend_d;
      pend_buf_q  <= pend_buf_d;
      cap_q       <= cap_d;
      cap_buf_q   <= cap_buf_d;
      a_vga_q     <= a_vga_d;
      pixel_q     <= pixel_d;
      pix_valid_q <= pix_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign a_vga     = a_vga_q;
  assign pixel     = pixel_q;
  assign pix_valid = pix_valid_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch. Stimulus pushes the expected pixel for each request
// into a queue. A monitor pops the queue and compares on every pix_valid.
module tb_vga_pixel_fetch;

  localparam int unsigned AW    = 17;
  localparam int unsigned N     = 8;
  localparam int unsigned R     = 6;
  localparam int unsigned IMG_W = 384;
  localparam int unsigned IMG_H = 4;   // short frame keeps the frame-end case reachable
  localparam int unsigned WPL   = IMG_W / R;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           frame_start = 1'b0;
  logic           line_start = 1'b0;
  logic           pix_req = 1'b0;
  logic [R*N-1:0] vram_i = '0;
  logic [AW-1:0]  a_vga;
  logic [N-1:0]   pixel;
  logic           pix_valid;
  logic           underrun;

  int             n_chk = 0;
  int             n_fail = 0;
  logic [N-1:0]   exp_q[$];

  vga_pixel_fetch #(
    .AW        (AW),
    .N         (N),
    .R         (R),
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .BASE_ADDR ('0),
    .BG        (8'h00)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .line_start  (line_start),
    .pix_req     (pix_req),
    .vram_i      (vram_i),
    .a_vga       (a_vga),
    .pixel       (pixel),
    .pix_valid   (pix_valid),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  // data_ram model: one-cycle read latency; byte j of word a is a*R + j + 1
  always @(posedge clk) begin
    for (int j = 0; j < R; j++) vram_i[j*N +: N] <= 8'((int'(a_vga) * R + j + 1) & 255);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [N-1:0] pix_of(input int line, input int p);
    return 8'((line * IMG_W + p + 1) & 255);
  endfunction

  // One clock cycle of stimulus; the expected response is queued for requests.
  task automatic step(input logic rq, input logic ls, input logic fs, input logic [N-1:0] e);
    pix_req     = rq;
    line_start  = ls;
    frame_start = fs;
    if (rq && reset) exp_q.push_back(e);
    @(posedge clk);
    #1;
    pix_req     = 1'b0;
    line_start  = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic run_pix(input int line, input int first, input int count);
    for (int p = first; p < first + count; p++) step(1'b1, 1'b0, 1'b0, pix_of(line, p));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Monitor: every presented pixel must match the oldest queued expectation.
  always @(negedge clk) begin
    if (pix_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pix_valid: got pixel %0h, expected no pix_valid at %0t",
                 pixel, $time);
      end else begin
        check("pixel", {24'h0, pixel}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset held 3 cycles with requests active
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
    check("rst_a_vga", 32'(a_vga), 32'd0);
    check("rst_pixel", 32'(pixel), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    reset = 1'b1;
    idle(2);

    // 2: first 12 pixels of line 0
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("fetch_w0", 32'(a_vga), 32'd0);
    idle(1);
    check("fetch_w1", 32'(a_vga), 32'd1);
    idle(1);
    run_pix(0, 0, 6);
    check("fetch_w2", 32'(a_vga), 32'd2);
    run_pix(0, 6, 6);
    check("fetch_w3", 32'(a_vga), 32'd3);
    check("no_underrun_l0", 32'(underrun), 32'd0);

    // 3: rest of line 0, then 4 extra requests
    run_pix(0, 12, IMG_W - 12);
    check("last_fetch", 32'(a_vga), 32'(WPL - 1));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
    check("hold_after_line", 32'(a_vga), 32'(WPL - 1));
    check("no_underrun_full", 32'(underrun), 32'd0);

    // Remaining lines of the frame
    for (int l = 1; l < IMG_H; l++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check("line_base", 32'(a_vga), 32'(l * WPL));
      idle(2);
      run_pix(l, 0, IMG_W);
    end
    check("no_underrun_frame", 32'(underrun), 32'd0);

    // 4: line_start past the last line fetches nothing
    step(1'b0, 1'b1, 1'b0, 8'h00);
    idle(1);
    check("no_fetch_past_h", 32'(a_vga), 32'(IMG_H * WPL - 1));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
    check("no_fetch_past_h2", 32'(a_vga), 32'(IMG_H * WPL - 1));
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("refetch_frame", 32'(a_vga), 32'd0);

    // 5: request coinciding with line_start underruns, and the flag is sticky
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    check("underrun_set", 32'(underrun), 32'd1);
    idle(2);
    run_pix(0, 0, IMG_W);
    for (int l = 1; l < 3; l++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check("underrun_sticky", 32'(underrun), 32'd1);
      idle(2);
      run_pix(l, 0, IMG_W);
    end

    // 6: reset in the middle of line 3
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("line3_base", 32'(a_vga), 32'(3 * WPL));
    idle(2);
    run_pix(3, 0, 100);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
    check("mid_rst_valid", 32'(pix_valid), 32'd0);
    check("mid_rst_underrun", 32'(underrun), 32'd0);
    check("mid_rst_a_vga", 32'(a_vga), 32'd0);
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("restart_line0", 32'(a_vga), 32'd0);
    idle(2);
    run_pix(0, 0, 12);
    check("restart_no_underrun", 32'(underrun), 32'd0);

    // frame_start clears the sticky flag
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    check("underrun_set2", 32'(underrun), 32'd1);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("underrun_cleared", 32'(underrun), 32'd0);

    idle(4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
